// File: rtl/lcd_nibble_reader.sv
// Timed 4-bit HD44780 read cycles (RW=1): assembles two nibbles into a byte and
// optionally re-reads the busy flag until it clears or the poll limit is reached.
module lcd_nibble_reader #(
  parameter int SETUP_CYC = 3,
  parameter int EHIGH_CYC = 13,
  parameter int HOLD_CYC  = 3,
  parameter int GAP_CYC   = 50,
  parameter int POLL_MAX  = 2000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  input  logic [3:0] lcd_data_in,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       oRelease,
  output logic       oReady,
  output logic       oDone,
  output logic [7:0] oData,
  output logic       oBF,
  output logic       oTimeout
);

  typedef enum logic [3:0] {
    IDLE, SETUP_H, EHIGH_H, HOLD_H, GAP, SETUP_L, EHIGH_L, HOLD_L, DONE
  } state_t;

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] EHIGH_LAST = 16'(EHIGH_CYC - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);
  localparam logic [16:0] POLL_LIMIT = 17'(POLL_MAX);

  state_t      state_reg, state_next;
  logic [15:0] phase_reg;
  logic [15:0] poll_cnt_reg;
  logic        rs_reg, poll_reg, repoll_reg;
  logic [3:0]  hi_reg, lo_reg;
  logic        lcd_e_reg, lcd_rs_reg, lcd_rw_reg, release_reg, ready_reg;
  logic        done_reg, bf_reg, timeout_reg;
  logic [7:0]  data_reg;
  logic        poll_again;
  logic        busy_next;
  logic        rs_next;

  // Another busy-flag read is warranted only while BF is still set and the
  // limit leaves room for one more full read.
  assign poll_again = poll_reg && !rs_reg && hi_reg[3] &&
                      (({1'b0, poll_cnt_reg} + 17'd1) < POLL_LIMIT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (iStart) state_next = SETUP_H;
      SETUP_H: if (phase_reg == SETUP_LAST) state_next = EHIGH_H;
      EHIGH_H: if (phase_reg == EHIGH_LAST) state_next = HOLD_H;
      HOLD_H:  if (phase_reg == HOLD_LAST)  state_next = GAP;
      GAP:     if (phase_reg == GAP_LAST)   state_next = repoll_reg ? SETUP_H : SETUP_L;
      SETUP_L: if (phase_reg == SETUP_LAST) state_next = EHIGH_L;
      EHIGH_L: if (phase_reg == EHIGH_LAST) state_next = HOLD_L;
      HOLD_L:  if (phase_reg == HOLD_LAST)  state_next = poll_again ? GAP : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy_next = (state_next != IDLE) && (state_next != DONE);
  assign rs_next   = (state_reg == IDLE) ? iRS : rs_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg    <= IDLE;
      phase_reg    <= '0;
      poll_cnt_reg <= '0;
      rs_reg       <= 1'b0;
      poll_reg     <= 1'b0;
      repoll_reg   <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      lcd_e_reg    <= 1'b0;
      lcd_rs_reg   <= 1'b0;
      lcd_rw_reg   <= 1'b0;
      release_reg  <= 1'b0;
      ready_reg    <= 1'b1;
      done_reg     <= 1'b0;
      data_reg     <= '0;
      bf_reg       <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= (state_next != state_reg || state_reg == IDLE) ? 16'd0 : phase_reg + 16'd1;

      if (state_reg == IDLE && iStart) begin
        rs_reg       <= iRS;
        poll_reg     <= iPoll;
        poll_cnt_reg <= '0;
        repoll_reg   <= 1'b0;
      end
      if (state_reg == EHIGH_H && state_next == HOLD_H) hi_reg <= lcd_data_in;
      if (state_reg == EHIGH_L && state_next == HOLD_L) lo_reg <= lcd_data_in;
      if (state_reg == HOLD_L && state_next == GAP) begin
        poll_cnt_reg <= poll_cnt_reg + 16'd1;
        repoll_reg   <= 1'b1;
      end
      if (state_reg == GAP && state_next == SETUP_H) repoll_reg <= 1'b0;

      if (state_next == DONE) begin
        data_reg    <= {hi_reg, lo_reg};
        bf_reg      <= !rs_reg && hi_reg[3];
        timeout_reg <= poll_reg && !rs_reg && hi_reg[3];
      end

      // Pin outputs are registered from the next state so the LCD never sees decode glitches.
      lcd_e_reg   <= (state_next == EHIGH_H) || (state_next == EHIGH_L);
      lcd_rw_reg  <= busy_next;
      release_reg <= busy_next;
      lcd_rs_reg  <= busy_next && rs_next;
      ready_reg   <= (state_next == IDLE);
      done_reg    <= (state_next == DONE);
    end
  end

  assign lcd_e    = lcd_e_reg;
  assign lcd_rs   = lcd_rs_reg;
  assign lcd_rw   = lcd_rw_reg;
  assign oRelease = release_reg;
  assign oReady   = ready_reg;
  assign oDone    = done_reg;
  assign oData    = data_reg;
  assign oBF      = bf_reg;
  assign oTimeout = timeout_reg;

endmodule

// File: tb/tb_lcd_nibble_reader.sv
// Bench for lcd_nibble_reader: an LCD nibble model feeds DB7..DB4 on each E pulse and
// a transaction-level model predicts read count, result byte, flags and latency.
module tb_lcd_nibble_reader;

  localparam int S  = 3;
  localparam int EH = 13;
  localparam int H  = 3;
  localparam int G  = 50;
  localparam int PM = 4;
  localparam int READ_CYC   = 2 * (S + EH + H) + G;
  localparam int POLL_EXTRA = G + 2 * (S + EH + H) + G;
  localparam int E_LOW_RUN  = H + G + S;

  logic       clk = 1'b0;
  logic       Reset, iStart, iRS, iPoll;
  logic [3:0] lcd_data_in;
  logic       lcd_e, lcd_rs, lcd_rw, oRelease, oReady, oDone, oBF, oTimeout;
  logic [7:0] oData;

  always #5 clk = ~clk;

  lcd_nibble_reader #(
    .SETUP_CYC(S), .EHIGH_CYC(EH), .HOLD_CYC(H), .GAP_CYC(G), .POLL_MAX(PM)
  ) dut (
    .Clock(clk), .Reset(Reset), .iStart(iStart), .iRS(iRS), .iPoll(iPoll),
    .lcd_data_in(lcd_data_in), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .oRelease(oRelease), .oReady(oReady), .oDone(oDone), .oData(oData),
    .oBF(oBF), .oTimeout(oTimeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] nib_q[$];
  logic [7:0] txn_bytes [6];
  int   pulses, e_run, low_run;
  logic prev_e = 1'b0, prev_rs = 1'b0, prev_rw = 1'b0;

  typedef struct {
    int lat; int dones; int pulses;
    logic [7:0] d; logic bf; logic to;
    logic rw1; logic rs1; logic rel1; logic rdy1;
  } obs_t;

  // Advance one clock, sample at the falling edge, play the LCD and check bus rules.
  task automatic tick();
    @(negedge clk);
    if (lcd_e) begin
      n_checks++;
      if (!oRelease) begin
        n_fail++;
        $display("FAIL e_release: lcd_e=1 with oRelease=%0b, required 1", oRelease);
      end
      if (prev_e) begin
        n_checks++;
        if (lcd_rs !== prev_rs || lcd_rw !== prev_rw) begin
          n_fail++;
          $display("FAIL rs_rw_stable: rs/rw %0b/%0b while E high, required %0b/%0b",
                   lcd_rs, lcd_rw, prev_rs, prev_rw);
        end
        e_run++;
      end else begin
        pulses++;
        if (pulses > 1) begin
          n_checks++;
          if (low_run != E_LOW_RUN) begin
            n_fail++;
            $display("FAIL e_low_time: E low %0d clocks, required %0d", low_run, E_LOW_RUN);
          end
        end
        lcd_data_in = (nib_q.size() > 0) ? nib_q.pop_front() : 4'h0;
        e_run = 1;
      end
      low_run = 0;
    end else begin
      if (prev_e && !Reset) begin
        n_checks++;
        if (e_run != EH) begin
          n_fail++;
          $display("FAIL e_high_time: E high %0d clocks, required %0d", e_run, EH);
        end
      end
      low_run++;
    end
    prev_e  = lcd_e;
    prev_rs = lcd_rs;
    prev_rw = lcd_rw;
  endtask

  task automatic load_bytes();
    nib_q.delete();
    for (int i = 0; i < 6; i++) begin
      nib_q.push_back(txn_bytes[i][7:4]);
      nib_q.push_back(txn_bytes[i][3:0]);
    end
  endtask

  // Poll mode keeps reading while BF is set, up to PM full reads; the result is the last read.
  task automatic model(input logic rs, input logic poll, output int reads, output int lat,
                       output logic [7:0] d, output logic bf, output logic to);
    reads = 1;
    if (poll && !rs)
      while (txn_bytes[reads-1][7] && reads < PM) reads++;
    d   = txn_bytes[reads-1];
    bf  = !rs && d[7];
    to  = poll && !rs && d[7];
    lat = READ_CYC + (reads - 1) * POLL_EXTRA;
  endtask

  task automatic run_txn(input logic rs, input logic poll, input int glitch_tick, output obs_t o);
    load_bytes();
    pulses = 0; low_run = 0;
    iRS = rs; iPoll = poll; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    o.rw1 = lcd_rw; o.rs1 = lcd_rs; o.rel1 = oRelease; o.rdy1 = oReady;
    o.lat = -1; o.dones = 0; o.d = '0; o.bf = 1'b0; o.to = 1'b0;
    for (int t = 1; t < 3000; t++) begin
      if (oDone) begin
        o.dones++;
        if (o.lat < 0) begin
          o.lat = t - 1; o.d = oData; o.bf = oBF; o.to = oTimeout;
        end
      end
      if (o.lat >= 0 && t >= o.lat + 4) break;
      iStart = (t == glitch_tick);
      tick();
    end
    iStart = 1'b0;
    o.pulses = pulses;
  endtask

  task automatic check_txn(input string name, input logic rs, input logic poll, input obs_t o);
    int reads, lat; logic [7:0] d; logic bf, to;
    model(rs, poll, reads, lat, d, bf, to);
    n_checks += 6;
    if (o.lat != lat) begin n_fail++; $display("FAIL %s latency: got %0d required %0d", name, o.lat, lat); end
    if (o.dones != 1) begin n_fail++; $display("FAIL %s done_count: got %0d required 1", name, o.dones); end
    if (o.pulses != 2 * reads) begin n_fail++; $display("FAIL %s e_pulses: got %0d required %0d", name, o.pulses, 2 * reads); end
    if (o.d !== d) begin n_fail++; $display("FAIL %s data: got %02h required %02h", name, o.d, d); end
    if (o.bf !== bf) begin n_fail++; $display("FAIL %s bf: got %0b required %0b", name, o.bf, bf); end
    if (o.to !== to) begin n_fail++; $display("FAIL %s timeout: got %0b required %0b", name, o.to, to); end
    $display("txn %s rs=%0b poll=%0b reads=%0d data=%02h bf=%0b to=%0b lat=%0d",
             name, rs, poll, reads, o.d, o.bf, o.to, o.lat);
  endtask

  task automatic test_reset();
    n_checks++;
    if ({lcd_e, lcd_rs, lcd_rw, oRelease, oReady, oDone, oData, oBF, oTimeout} !== {6'b000010, 8'h00, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: e/rs/rw/rel/rdy/done=%0b%0b%0b%0b%0b%0b data=%02h bf=%0b to=%0b, required 000010 00 0 0",
               lcd_e, lcd_rs, lcd_rw, oRelease, oReady, oDone, oData, oBF, oTimeout);
    end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    txn_bytes = '{8'h4A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load_bytes();
    pulses = 0; low_run = 0;
    iRS = 1'b1; iPoll = 1'b0; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int t = 0; t < 300 && !(pulses == 2 && lcd_e); t++) tick();
    n_checks++;
    if (!(pulses == 2 && lcd_e)) begin
      n_fail++;
      $display("FAIL abort_reach_ehigh_l: pulses=%0d lcd_e=%0b, required 2/1", pulses, lcd_e);
    end
    Reset = 1'b1;
    tick();
    n_checks++;
    if ({lcd_e, oRelease, oReady, oDone, lcd_rw} !== 5'b00100) begin
      n_fail++;
      $display("FAIL abort_outputs: e/rel/rdy/done/rw=%0b%0b%0b%0b%0b required 00100",
               lcd_e, oRelease, oReady, oDone, lcd_rw);
    end
    Reset = 1'b0;
    for (int t = 0; t < 150; t++) begin
      tick();
      if (oDone) dones++;
    end
    n_checks += 2;
    if (dones != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d dones required 0", dones); end
    if (oData !== 8'h00) begin n_fail++; $display("FAIL abort_data: got %02h required 00", oData); end
    $display("txn abort dones=%0d data=%02h", dones, oData);
  endtask

  task automatic test_data_read();
    obs_t o;
    txn_bytes = '{8'h45, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_txn(1'b1, 1'b0, 0, o);
    n_checks++;
    if ({o.rw1, o.rs1, o.rel1, o.rdy1} !== 4'b1110) begin
      n_fail++;
      $display("FAIL start_pins: rw/rs/rel/rdy=%0b%0b%0b%0b required 1110", o.rw1, o.rs1, o.rel1, o.rdy1);
    end
    check_txn("data_read", 1'b1, 1'b0, o);
  endtask

  task automatic test_poll();
    obs_t o;
    txn_bytes = '{8'h8C, 8'hB3, 8'hF0, 8'h07, 8'h80, 8'h80};
    run_txn(1'b0, 1'b1, 0, o);
    check_txn("poll", 1'b0, 1'b1, o);
  endtask

  task automatic test_timeout();
    obs_t o;
    txn_bytes = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86};
    run_txn(1'b0, 1'b1, 0, o);
    check_txn("timeout", 1'b0, 1'b1, o);
  endtask

  task automatic test_random();
    obs_t o;
    logic rs, poll;
    for (int n = 0; n < 8; n++) begin
      rs   = 1'($urandom_range(0, 1));
      poll = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 6; i++) begin
        txn_bytes[i] = 8'($urandom);
        txn_bytes[i][7] = ($urandom_range(0, 2) != 0);
      end
      run_txn(rs, poll, 0, o);
      check_txn("random", rs, poll, o);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int lat2 = -1;
    txn_bytes = '{8'h3C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_txn(1'b1, 1'b0, 40, o);
    check_txn("ignored_start", 1'b1, 1'b0, o);

    // Second phase: iStart held high across DONE restarts from IDLE one cycle later.
    txn_bytes = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    load_bytes();
    pulses = 0; low_run = 0;
    iRS = 1'b1; iPoll = 1'b0; iStart = 1'b1;
    tick();
    for (int t = 0; t < 300 && !oDone; t++) tick();
    n_checks++;
    if (oData !== 8'hA5) begin n_fail++; $display("FAIL hold_first_data: got %02h required a5", oData); end
    tick();
    n_checks++;
    if ({oReady, oDone, oRelease} !== 3'b100) begin
      n_fail++;
      $display("FAIL hold_idle_cycle: rdy/done/rel=%0b%0b%0b required 100", oReady, oDone, oRelease);
    end
    tick();
    n_checks++;
    if ({oReady, lcd_rw, oRelease} !== 3'b011) begin
      n_fail++;
      $display("FAIL hold_restart: rdy/rw/rel=%0b%0b%0b required 011", oReady, lcd_rw, oRelease);
    end
    iStart = 1'b0;
    pulses = 0; low_run = 0;
    for (int t = 1; t < 300; t++) begin
      if (oDone) begin lat2 = t - 1; break; end
      tick();
    end
    n_checks += 2;
    if (lat2 != READ_CYC) begin n_fail++; $display("FAIL hold_second_latency: got %0d required %0d", lat2, READ_CYC); end
    if (oData !== 8'h5A) begin n_fail++; $display("FAIL hold_second_data: got %02h required 5a", oData); end
    $display("txn hold_restart data=%02h lat=%0d", oData, lat2);
    tick();
  endtask

  initial begin
    Reset = 1'b1; iStart = 1'b0; iRS = 1'b0; iPoll = 1'b0; lcd_data_in = 4'h0;
    pulses = 0; e_run = 0; low_run = 0;
    repeat (3) tick();
    test_reset();
    Reset = 1'b0;
    tick();
    test_reset();
    test_reset_abort();
    test_data_read();
    test_poll();
    test_timeout();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
